// File: rtl/pipe_ctrl_if.sv
// Control bundle between the pipeline controller and the if/id/ex datapath.
// master = controller side, slave = datapath side.
interface pipe_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             jump_en_i;
    logic [31:0]      jump_addr_i;
    logic             hold_req_i;
    logic [4:0]       id_rs1_addr_i;
    logic [4:0]       id_rs2_addr_i;
    logic [4:0]       ex_rd_addr_i;
    logic             ex_reg_wen_i;
    logic             jump_en_o;
    logic [31:0]      jump_addr_o;
    logic             hold_pc_o;
    logic             hold_if_id_o;
    logic             hold_id_ex_o;
    logic             flush_if_id_o;
    logic             flush_id_ex_o;
    logic [CNT_W-1:0] flush_cnt_o;
    logic [CNT_W-1:0] stall_cnt_o;

    modport master (
        input  jump_en_i, jump_addr_i, hold_req_i, id_rs1_addr_i, id_rs2_addr_i,
               ex_rd_addr_i, ex_reg_wen_i,
        output jump_en_o, jump_addr_o, hold_pc_o, hold_if_id_o, hold_id_ex_o,
               flush_if_id_o, flush_id_ex_o, flush_cnt_o, stall_cnt_o
    );

    modport slave (
        output jump_en_i, jump_addr_i, hold_req_i, id_rs1_addr_i, id_rs2_addr_i,
               ex_rd_addr_i, ex_reg_wen_i,
        input  jump_en_o, jump_addr_o, hold_pc_o, hold_if_id_o, hold_id_ex_o,
               flush_if_id_o, flush_id_ex_o, flush_cnt_o, stall_cnt_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hold/flush sequencer: redirect, external hold and RAW-hazard bubbles.
// Outputs are combinational (same cycle); external hold freezes the whole front end.
module pipe_ctrl #(
    parameter int STALL_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.master bus
);
    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] STALL = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;
    localparam logic [1:0] JPEND = 2'd3;
    localparam logic [3:0] STALL_INIT = 4'(STALL_CYCLES - 1);

    logic [1:0]       state, state_n;
    logic [3:0]       cnt, cnt_n;
    logic             pend_vld, pend_vld_n;
    logic [31:0]      pend_addr, pend_addr_n;
    logic             ret_stall, ret_stall_n;
    logic [CNT_W-1:0] flush_cnt, stall_cnt;

    logic        hazard;
    logic        jump_c, hold_pc_c, hold_if_id_c, hold_id_ex_c;
    logic        flush_if_id_c, flush_id_ex_c, bubble_c;
    logic [31:0] addr_c;

    assign hazard = bus.ex_reg_wen_i && (bus.ex_rd_addr_i != 5'd0) &&
                    ((bus.ex_rd_addr_i == bus.id_rs1_addr_i) ||
                     (bus.ex_rd_addr_i == bus.id_rs2_addr_i));

    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        pend_vld_n    = pend_vld;
        pend_addr_n   = pend_addr;
        ret_stall_n   = ret_stall;
        jump_c        = 1'b0;
        addr_c        = 32'd0;
        hold_pc_c     = 1'b0;
        hold_if_id_c  = 1'b0;
        hold_id_ex_c  = 1'b0;
        flush_if_id_c = 1'b0;
        flush_id_ex_c = 1'b0;
        bubble_c      = 1'b0;
        case (state)
            RUN, STALL: begin
                if (bus.hold_req_i) begin
                    hold_pc_c    = 1'b1;
                    hold_if_id_c = 1'b1;
                    hold_id_ex_c = 1'b1;
                    if (bus.jump_en_i) begin
                        pend_vld_n  = 1'b1;
                        pend_addr_n = bus.jump_addr_i;
                    end
                    ret_stall_n = (state == STALL);
                    state_n     = HOLD;
                end else if (bus.jump_en_i) begin
                    jump_c        = 1'b1;
                    addr_c        = bus.jump_addr_i;
                    flush_if_id_c = 1'b1;
                    flush_id_ex_c = 1'b1;
                    cnt_n         = 4'd0;
                    state_n       = RUN;
                end else if ((state == STALL) || hazard) begin
                    bubble_c      = 1'b1;
                    hold_pc_c     = 1'b1;
                    hold_if_id_c  = 1'b1;
                    flush_id_ex_c = 1'b1;
                    if (state == RUN) begin
                        if (STALL_CYCLES > 1) begin
                            cnt_n   = STALL_INIT;
                            state_n = STALL;
                        end
                    end else begin
                        cnt_n = cnt - 4'd1;
                        if (cnt == 4'd1) state_n = RUN;
                    end
                end
            end
            HOLD: begin
                hold_pc_c    = 1'b1;
                hold_if_id_c = 1'b1;
                hold_id_ex_c = 1'b1;
                // Latest redirect wins, including one arriving in the exit cycle.
                if (bus.jump_en_i) begin
                    pend_vld_n  = 1'b1;
                    pend_addr_n = bus.jump_addr_i;
                end
                if (!bus.hold_req_i) begin
                    ret_stall_n = 1'b0;
                    if (pend_vld || bus.jump_en_i) state_n = JPEND;
                    else if (ret_stall)            state_n = STALL;
                    else                           state_n = RUN;
                end
            end
            JPEND: begin
                jump_c        = 1'b1;
                addr_c        = pend_addr;
                flush_if_id_c = 1'b1;
                flush_id_ex_c = 1'b1;
                pend_vld_n    = 1'b0;
                ret_stall_n   = 1'b0;
                cnt_n         = 4'd0;
                state_n       = RUN;
            end
            default: state_n = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            cnt       <= 4'd0;
            pend_vld  <= 1'b0;
            pend_addr <= 32'd0;
            ret_stall <= 1'b0;
            flush_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            pend_vld  <= pend_vld_n;
            pend_addr <= pend_addr_n;
            ret_stall <= ret_stall_n;
            if (jump_c && (flush_cnt != '1))   flush_cnt <= flush_cnt + 1'b1;
            if (bubble_c && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign bus.jump_en_o     = !rst && jump_c;
    assign bus.jump_addr_o   = rst ? 32'd0 : addr_c;
    assign bus.hold_pc_o     = !rst && hold_pc_c;
    assign bus.hold_if_id_o  = !rst && hold_if_id_c;
    assign bus.hold_id_ex_o  = !rst && hold_id_ex_c;
    assign bus.flush_if_id_o = !rst && flush_if_id_c;
    assign bus.flush_id_ex_o = !rst && flush_id_ex_c;
    assign bus.flush_cnt_o   = flush_cnt;
    assign bus.stall_cnt_o   = stall_cnt;
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline controller for the if / if_id / id / id_ex / ex core.
- Sequences the pipeline registers: PC hold, if_id hold and flush, id_ex hold and flush.
- Arbitrates between three requesters:
  - ex-stage branch/jump redirect.
  - External multi-cycle hold request (bus/memory busy).
  - RAW hazard between the id source registers and the ex destination.
- Keeps saturating flush and stall event counters for debug.

Parameters:
- STALL_CYCLES, 1, bubble cycles inserted per RAW hazard (legal range 1..15).
- CNT_W, 16, width of each event counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- jump_en_i  in  1  ex requests a redirect this cycle.
- jump_addr_i  in  32  redirect target.
- hold_req_i  in  1  external hold; level, any length.
- id_rs1_addr_i  in  5  rs1 address from id (0 when unused).
- id_rs2_addr_i  in  5  rs2 address from id (0 when unused).
- ex_rd_addr_i  in  5  rd of the instruction in ex.
- ex_reg_wen_i  in  1  the ex instruction writes rd.
- jump_en_o  out  1  PC loads jump_addr_o.
- jump_addr_o  out  32  PC redirect target.
- hold_pc_o  out  1  PC keeps its value.
- hold_if_id_o  out  1  if_id keeps its contents.
- hold_id_ex_o  out  1  id_ex keeps its contents.
- flush_if_id_o  out  1  if_id loads NOP (0x00000013), addr 0.
- flush_id_ex_o  out  1  id_ex loads NOP, rd 0, wen 0.
- flush_cnt_o  out  CNT_W  number of redirect cycles.
- stall_cnt_o  out  CNT_W  number of hazard bubble cycles.

Behaviour:
- Hazard is defined as: ex_reg_wen_i && ex_rd_addr_i != 0 && (ex_rd_addr_i == id_rs1_addr_i || ex_rd_addr_i == id_rs2_addr_i).
- States: RUN, STALL, HOLD, JPEND.
- Registers:
  - 4-bit stall counter cnt.
  - pend_vld, pend_addr[31:0].
  - ret_stall: return STALL after HOLD.
- Reset (rst high at a clk edge):
  - State goes to RUN; cnt, pend_vld, pend_addr, ret_stall and both counters go to 0.
  - While rst is high, all control outputs are forced to 0 and jump_addr_o is 0.
- Control outputs are combinational from state and inputs, so they act in the same cycle.
- Sequential updates happen on the clk edge.
- Priority within a cycle: rst > hold_req_i > jump > hazard.
- RUN:
  - hold_req_i=1:
    - hold_pc_o, hold_if_id_o and hold_id_ex_o are 1; no flush.
    - If jump_en_i is also 1: pend_vld<=1, pend_addr<=jump_addr_i.
    - Next state HOLD, ret_stall<=0.
  - else jump_en_i=1:
    - jump_en_o=1, jump_addr_o=jump_addr_i, flush_if_id_o=1, flush_id_ex_o=1; hazard is ignored.
    - Stay in RUN.
  - else hazard:
    - hold_pc_o=1, hold_if_id_o=1, flush_id_ex_o=1 (bubble).
    - If STALL_CYCLES>1: cnt<=STALL_CYCLES-1, next state STALL; otherwise stay in RUN.
  - else: all control outputs are 0.
- STALL:
  - Outputs the same bubble as RUN-hazard.
  - cnt decrements each cycle; when cnt==1 the next state is RUN.
  - jump_en_i=1 (no hold): redirect exactly as in RUN, cnt<=0, next state RUN.
  - hold_req_i=1: behaves as RUN-hold with cnt frozen, ret_stall<=1, next state HOLD.
- HOLD:
  - All three holds are 1; no flush.
  - Each cycle with jump_en_i=1 overwrites pend_addr and sets pend_vld (the latest request wins).
  - On hold_req_i=0:
    - If pend_vld: next state JPEND; the holds are still 1 in this exit cycle.
    - else if ret_stall: next state STALL.
    - else: next state RUN.
- JPEND (exactly 1 cycle):
  - jump_en_o=1, jump_addr_o=pend_addr, both flushes 1; jump_en_i is ignored.
  - pend_vld<=0.
  - Next state RUN (any remaining stall is dropped, because the flush kills the consumer).
  - If hold_req_i reasserts in JPEND, the redirect still completes this cycle; then RUN handles the hold.
- jump_addr_o is 0 whenever jump_en_o=0.
- Counters:
  - flush_cnt_o increments on every cycle with jump_en_o=1.
  - stall_cnt_o increments on every hazard-bubble cycle (RUN-hazard or STALL).
  - Both saturate at all-ones and never wrap.
- Hold and flush are never both 1 for the same register in the same cycle.

Test Plan:
- Reset with all inputs high, rst=1 for 2 cycles -> every output 0; after release with idle inputs, outputs stay 0 and counters stay 0.
- jump_en_i=1, jump_addr_i=0x00000040 for 1 cycle in RUN -> same cycle jump_en_o=1, addr 0x40, both flushes 1; flush_cnt_o=1 next cycle.
- STALL_CYCLES=3, ex_rd=5, wen=1, id_rs2=5:
  - Expect 3 consecutive bubble cycles (hold_pc, hold_if_id, flush_id_ex), then outputs 0; stall_cnt_o=3.
  - Repeat with ex_rd=0 -> no bubble.
- hold_req_i high for 4 cycles, jump_en_i pulses addr 0x100 in cycle 1 and 0x200 in cycle 3:
  - Holds are 1 for 4 cycles.
  - The cycle after release: jump_en_o=1, addr 0x200, both flushes; then RUN.
- STALL_CYCLES=4: hazard, then hold_req_i for 2 cycles mid-stall -> bubble count still totals 4, with the holds in between.
- Force stall_cnt_o to 0xFFFE via 3 more bubbles -> reads 0xFFFF and stays there; rst mid-HOLD with pend_vld=1 -> no redirect after release.
